// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer
//   Walks the register bank debug port over an inclusive, possibly wrapping
//   index range and serialises every register as a frame on a valid/ready
//   byte stream. Each frame is the index byte followed by the DATA_W/8 data
//   bytes, least-significant byte first. The core's normal read/write ports
//   are untouched; only the bank's debug port is used.
//
// Ports
//   clk          clock
//   rst_async    asynchronous reset, active-high; aborts any dump in flight
//   start        begin a dump (only honoured while idle)
//   first_index  first register of the range, latched on an accepted start
//   last_index   last register of the range (inclusive), latched with start
//   debug_index  register select driven to the bank debug port
//   debug        combinational read data returned by the bank debug port
//   out_valid    out_data holds a byte for the sink
//   out_data     stream byte
//   out_ready    sink accepts the byte when out_valid && out_ready
//   out_last     marks the final byte of the final frame of the dump
//   busy         high whenever a dump is in progress (any non-idle state)
//   done         single-cycle pulse once the final byte has been accepted
module reg_dump_streamer #(
    parameter int NUM_REGS = 16,
    parameter int INDEX_W  = 4,
    parameter int DATA_W   = 32
) (
    input  logic               clk,
    input  logic               rst_async,
    input  logic               start,
    input  logic [INDEX_W-1:0] first_index,
    input  logic [INDEX_W-1:0] last_index,
    output logic [INDEX_W-1:0] debug_index,
    input  logic [DATA_W-1:0]  debug,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    // byte_cnt == 0 while the index byte is presented, 1..NBYTES for data.
    localparam logic [CNT_W-1:0] LAST_BYTE     = CNT_W'(NBYTES);
    localparam logic [CNT_W-1:0] PENULT_BYTE   = CNT_W'(NBYTES - 1);
    localparam logic [INDEX_W-1:0] TOP_INDEX   = INDEX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [INDEX_W-1:0] cur, cur_nxt;
    logic [INDEX_W-1:0] last_idx, last_idx_nxt;
    logic [DATA_W-1:0]  word, word_nxt;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic               out_valid_nxt;
    logic [7:0]         out_data_nxt;
    logic               out_last_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               fire;

    // Modulo-NUM_REGS increment; NUM_REGS need not be a power of two.
    function automatic logic [INDEX_W-1:0] next_index(input logic [INDEX_W-1:0] idx);
        if (idx == TOP_INDEX) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    assign fire        = out_valid && out_ready;
    // cur is itself a register, so the debug port select stays registered.
    assign debug_index = cur;

    always_comb begin
        state_nxt     = state;
        cur_nxt       = cur;
        last_idx_nxt  = last_idx;
        word_nxt      = word;
        byte_cnt_nxt  = byte_cnt;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_last_nxt  = out_last;
        busy_nxt      = busy;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = FETCH;
                    cur_nxt      = first_index;
                    last_idx_nxt = last_index;
                    busy_nxt     = 1'b1;
                end
            end

            FETCH: begin
                // debug has had a full cycle to settle on the new index;
                // snapshot it so bank writes during SEND cannot tear the frame.
                state_nxt     = SEND;
                word_nxt      = debug;
                byte_cnt_nxt  = '0;
                out_valid_nxt = 1'b1;
                out_data_nxt  = 8'(cur);
                out_last_nxt  = 1'b0;
            end

            SEND: begin
                if (fire) begin
                    if (byte_cnt == LAST_BYTE) begin
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        if (cur == last_idx) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = FETCH;
                            cur_nxt   = next_index(cur);
                        end
                    end else begin
                        // The snapshot shifts down so the next byte is always
                        // in the low lane, giving LSB-first order.
                        out_data_nxt = word[7:0];
                        word_nxt     = word >> 8;
                        byte_cnt_nxt = byte_cnt + 1'b1;
                        out_last_nxt = (byte_cnt == PENULT_BYTE) && (cur == last_idx);
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end

            default: begin
                state_nxt     = IDLE;
                out_valid_nxt = 1'b0;
                out_last_nxt  = 1'b0;
                busy_nxt      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state     <= IDLE;
            cur       <= '0;
            byte_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            byte_cnt  <= byte_cnt_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_last  <= out_last_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Snapshot and range end are always loaded before use, so no reset.
    always_ff @(posedge clk) begin
        word     <= word_nxt;
        last_idx <= last_idx_nxt;
    end

endmodule
